// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises the 27 MHz -> 81 MHz PLL from the crystal domain. It pulses the
//   PLL reset, then waits for lock with a timeout and a bounded number of
//   attempts. Lock must then stay stable for a full window before downstream
//   system reset is released. A lock loss or a software relock request starts
//   the sequence again. Repeated timeouts latch FAULT until rst_n.
//
// Ports
//   clkin       in   27 MHz crystal clock, all logic on its rising edge
//   rst_n       in   asynchronous active-low reset
//   pll_lock    in   raw PLL lock, asynchronous to clkin
//   relock_req  in   single-cycle re-sequence request, honoured only in RUN
//   pll_reset   out  PLL RESET input, active high
//   sys_rst_n   out  active-low reset for the 81 MHz logic. It asserts
//                    asynchronously with rst_n and deasserts on clkin.
//   ready       out  high only in RUN
//   fault       out  high only in FAULT, latched until rst_n
//   loss_cnt    out  saturating count of lock losses seen in RUN
//   retry_cnt   out  saturating count of lock-wait timeouts
//
// Configuration
//   PLL_SEQ_STATUS_EN : when defined, loss_cnt/retry_cnt are real counters.
//                       When undefined, both ports read 8'd0 and no counter
//                       flops are built.

module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 270000,
  parameter int unsigned STABLE_CYCLES = 27000,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] loss_cnt,
  output logic [7:0] retry_cnt
);

  localparam int unsigned ATT_W     = 4;
  localparam int unsigned ATT_CMP_W = ATT_W + 1;
  localparam int unsigned STAT_W    = 8;

  localparam logic [CNT_W-1:0]     RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]     LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [ATT_CMP_W-1:0] ATT_LIMIT   = ATT_CMP_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [1:0]         sync_q;
  logic               lock_s;

  logic pll_reset_q, pll_reset_d;
  logic sys_rst_n_q, sys_rst_n_d;
  logic ready_q,     ready_d;
  logic fault_q,     fault_d;

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
    end
  end

  assign lock_s = sync_q[1];

  // State register together with the shared phase counter and attempt counter
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET_PLL;
      cnt_q   <= '0;
      att_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
    end
  end

  // Next-state logic. The phase counter clears on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    att_d   = att_q;

    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          // Timed-out attempt; the old attempt count decides retry vs fault
          att_d = att_q + ATT_W'(1);
          if (({1'b0, att_q} + ATT_CMP_W'(1)) == ATT_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_RESET_PLL;
          end
        end
      end

      ST_STABLE: begin
        // A lock glitch gives a fresh lock-wait budget and does not count as a timeout
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          att_d   = '0;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s || relock_req) begin
          state_d = ST_RESET_PLL;
        end
      end

      ST_FAULT: begin
        cnt_d = cnt_q;
      end

      default: begin
        state_d = ST_RESET_PLL;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Output decode from the upcoming state, so outputs move on the transition edge
  always_comb begin
    pll_reset_d = 1'b0;
    sys_rst_n_d = 1'b0;
    ready_d     = 1'b0;
    fault_d     = 1'b0;

    unique case (state_d)
      ST_RESET_PLL: pll_reset_d = 1'b1;
      ST_WAIT_LOCK: pll_reset_d = 1'b0;
      ST_STABLE:    pll_reset_d = 1'b0;
      ST_RUN: begin
        sys_rst_n_d = 1'b1;
        ready_d     = 1'b1;
      end
      ST_FAULT: begin
        pll_reset_d = 1'b1;
        fault_d     = 1'b1;
      end
      default:      pll_reset_d = 1'b1;
    endcase
  end

  // Output registers; sys_rst_n asserts asynchronously with rst_n
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;

`ifdef PLL_SEQ_STATUS_EN
  logic              loss_ev_c;
  logic              timeout_ev_c;
  logic [STAT_W-1:0] loss_cnt_q;
  logic [STAT_W-1:0] retry_cnt_q;

  // A lock loss in RUN takes priority over a coincident relock request
  assign loss_ev_c    = (state_q == ST_RUN) && !lock_s;
  assign timeout_ev_c = (state_q == ST_WAIT_LOCK) && !lock_s && (cnt_q == LOCK_LAST);

  // Saturating status counters, cleared only by rst_n
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      if (loss_ev_c && (loss_cnt_q != {STAT_W{1'b1}})) begin
        loss_cnt_q <= loss_cnt_q + STAT_W'(1);
      end
      if (timeout_ev_c && (retry_cnt_q != {STAT_W{1'b1}})) begin
        retry_cnt_q <= retry_cnt_q + STAT_W'(1);
      end
    end
  end

  assign loss_cnt  = loss_cnt_q;
  assign retry_cnt = retry_cnt_q;
`else
  assign loss_cnt  = STAT_W'(0);
  assign retry_cnt = STAT_W'(0);
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with short timing parameters.
//   A phase/remaining-cycles model of the sequencing rules predicts every
//   output after each clock edge. Hand-computed edge counts pin the model.

module tb_pll_reset_sequencer;

  localparam int unsigned RST_C   = 4;
  localparam int unsigned LOCK_TO = 20;
  localparam int unsigned STAB_C  = 8;
  localparam int unsigned MAXR    = 3;

`ifdef PLL_SEQ_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic       clkin;
  logic       rst_n;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] loss_cnt;
  logic [7:0] retry_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pll_reset_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (LOCK_TO),
    .STABLE_CYCLES(STAB_C),
    .MAX_RETRIES  (MAXR),
    .CNT_W        (8)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .relock_req(relock_req),
    .pll_reset (pll_reset),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fault     (fault),
    .loss_cnt  (loss_cnt),
    .retry_cnt (retry_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_RST, P_WAIT, P_STAB, P_RUN, P_FLT} phase_e;
  phase_e m_ph;
  int     m_left;
  int     m_att;
  int     m_loss;
  int     m_retry;
  bit [1:0] m_hist;  // [0] newest raw sample, [1] value the decisions see

  task automatic m_enter(input phase_e p);
    m_ph = p;
    case (p)
      P_RST:   m_left = RST_C;
      P_WAIT:  m_left = LOCK_TO;
      P_STAB:  m_left = STAB_C;
      default: m_left = 0;
    endcase
  endtask

  task automatic m_reset();
    m_hist  = 2'b00;
    m_att   = 0;
    m_loss  = 0;
    m_retry = 0;
    m_enter(P_RST);
  endtask

  task automatic m_step();
    bit ls;
    ls = m_hist[1];
    case (m_ph)
      P_RST: if (m_left == 1) m_enter(P_WAIT); else m_left--;
      P_WAIT: begin
        if (ls) m_enter(P_STAB);
        else if (m_left == 1) begin
          m_att++;
          if (m_retry < 255) m_retry++;
          if (m_att == MAXR) m_enter(P_FLT); else m_enter(P_RST);
        end else m_left--;
      end
      P_STAB: begin
        if (!ls) m_enter(P_WAIT);
        else if (m_left == 1) begin
          m_att = 0;
          m_enter(P_RUN);
        end else m_left--;
      end
      P_RUN: begin
        if (!ls) begin
          if (m_loss < 255) m_loss++;
          m_enter(P_RST);
        end else if (relock_req) m_enter(P_RST);
      end
      default: ;
    endcase
    m_hist = {m_hist[0], pll_lock};
  endtask

  // Per-cycle compare, sampled 1 time unit after the active edge
  always @(posedge clkin) begin
    logic [3:0]  exp_ctl;
    logic [15:0] exp_cnt;
    if (!rst_n) m_reset();
    else m_step();
    #1;
    exp_ctl = {(m_ph == P_RST) || (m_ph == P_FLT), m_ph == P_RUN, m_ph == P_RUN, m_ph == P_FLT};
    exp_cnt = STATUS ? {8'(m_loss), 8'(m_retry)} : 16'h0;
    check("cycle_ctl", 32'({pll_reset, sys_rst_n, ready, fault}), 32'(exp_ctl));
    check("cycle_cnt", 32'({loss_cnt, retry_cnt}), 32'(exp_cnt));
  end

  // ---------------- directed stimulus ----------------
  task automatic edges_until_ready(input string nm, input int budget, output int e);
    e = 0;
    do begin
      @(negedge clkin);
      e++;
    end while (!ready && e < budget);
    check({nm, "_ready_reached"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int e, fall, rise, hi;
    bit early;
    rst_n      = 1'b0;
    pll_lock   = 1'b1;
    relock_req = 1'b0;
    repeat (3) @(negedge clkin);
    check("rst_ctl", 32'({pll_reset, sys_rst_n, ready, fault}), 32'(4'b1000));
    check("rst_cnt", 32'({loss_cnt, retry_cnt}), 32'd0);

    // 1: clean lock
    rst_n = 1'b1;
    e = 0; fall = -1; rise = -1; early = 1'b0;
    while (e < 40 && rise < 0) begin
      @(negedge clkin);
      e++;
      if (fall < 0 && !pll_reset) fall = e;
      if (ready) rise = e;
      else if (sys_rst_n) early = 1'b1;
    end
    check("s1_pll_reset_fall_edge", 32'(fall), 32'd4);
    check("s1_ready_edge", 32'(rise), 32'd13);
    check("s1_sys_rst_n_with_ready", 32'(sys_rst_n), 32'd1);
    check("s1_no_early_release", 32'(early), 32'd0);
    check("s1_fault_cnt", 32'({fault, loss_cnt, retry_cnt}), 32'd0);

    // 2: 1-cycle glitch midway through STABLE
    rst_n = 1'b0;
    @(negedge clkin);
    rst_n = 1'b1;
    repeat (8) @(negedge clkin);
    pll_lock = 1'b0;
    @(negedge clkin);
    pll_lock = 1'b1;
    edges_until_ready("s2", 40, e);
    check("s2_ready_edge", 32'(e + 9), 32'd20);
    check("s2_retry", 32'(retry_cnt), 32'd0);

    // 3: lock loss in RUN
    pll_lock = 1'b0;
    @(negedge clkin);
    e = 1;
    pll_lock = 1'b1;
    while (sys_rst_n && e < 10) begin
      @(negedge clkin);
      e++;
    end
    check("s3_sys_rst_fall_edge", 32'(e), 32'd3);
    hi = 0;
    while (pll_reset && hi < 20) begin
      hi++;
      @(negedge clkin);
    end
    check("s3_pll_reset_len", 32'(hi), 32'd4);
    edges_until_ready("s3", 40, e);
    check("s3_ready_edge", 32'(e + 7), 32'd16);
    check("s3_loss", 32'(loss_cnt), STATUS ? 32'd1 : 32'd0);

    // 5a: relock request in RUN
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
    check("s5a_resequence", 32'({sys_rst_n, ready, pll_reset}), 32'(3'b001));
    edges_until_ready("s5a", 40, e);
    check("s5a_ready_edge", 32'(e + 1), 32'd14);
    check("s5a_loss_unchanged", 32'(loss_cnt), STATUS ? 32'd1 : 32'd0);

    // 5b: relock request while waiting for lock is ignored
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
    pll_lock   = 1'b0;
    repeat (6) @(negedge clkin);
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
    @(negedge clkin);
    check("s5b_wait_ignores_relock", 32'({pll_reset, ready}), 32'd0);
    pll_lock = 1'b1;
    edges_until_ready("s5b", 40, e);
    check("s5b_ready_edge", 32'(e + 9), 32'd20);
    check("s5b_retry", 32'(retry_cnt), 32'd0);

    // 5c: relock coincident with lock drop counts one loss
    pll_lock = 1'b0;
    @(negedge clkin);
    pll_lock = 1'b1;
    @(negedge clkin);
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
    check("s5c_sys_rst_fall", 32'(sys_rst_n), 32'd0);
    check("s5c_loss_once", 32'(loss_cnt), STATUS ? 32'd2 : 32'd0);
    edges_until_ready("s5c", 40, e);
    check("s5c_ready_edge", 32'(e + 3), 32'd16);

    // 4: persistent failure
    pll_lock = 1'b0;
    e = 0;
    do begin
      @(negedge clkin);
      e++;
    end while (!fault && e < 200);
    check("s4_fault_edge", 32'(e), 32'd75);
    check("s4_retry", 32'(retry_cnt), STATUS ? 32'd3 : 32'd0);
    check("s4_loss", 32'(loss_cnt), STATUS ? 32'd3 : 32'd0);
    check("s4_fault_outs", 32'({pll_reset, sys_rst_n, ready}), 32'(3'b100));
    pll_lock = 1'b1;
    repeat (20) @(negedge clkin);
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
    repeat (20) @(negedge clkin);
    check("s4_fault_latched", 32'({fault, pll_reset, ready}), 32'(3'b110));
    rst_n = 1'b0;
    @(negedge clkin);
    check("s4_rst_clears", 32'({fault, pll_reset, sys_rst_n, loss_cnt, retry_cnt}), 32'(19'h20000));
    rst_n = 1'b1;
    edges_until_ready("s4_recover", 40, e);
    check("s4_recover_edge", 32'(e), 32'd13);

    // 6: saturation of loss_cnt
    for (int i = 0; i < 260; i++) begin
      pll_lock = 1'b0;
      @(negedge clkin);
      pll_lock = 1'b1;
      edges_until_ready("s6", 40, e);
    end
    check("s6_loss_saturated", 32'(loss_cnt), STATUS ? 32'd255 : 32'd0);
    check("s6_retry", 32'(retry_cnt), 32'd0);

    repeat (3) @(negedge clkin);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
